// File: rtl/gyro_demod_pkg.sv
// Shared types and constants for the fiber-gyro error demodulator and the
// integrator path that reuses the 32-bit saturator.
package gyro_demod_pkg;

  typedef enum logic [2:0] {
    INIT,
    HIGH_WAIT,
    HIGH_ACC,
    LOW_WAIT,
    LOW_ACC
  } state_e;

  localparam int unsigned ACC_W = 48;
  localparam int unsigned PER_W = 8;

  localparam logic signed [31:0] ERR_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] ERR_MIN = 32'sh8000_0000;

endpackage

// File: rtl/gyro_err_demod_sat32.sv
// Combinational saturation of a signed accumulator-width value to 32 bits.
module demod_sat32
  import gyro_demod_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_val,
  output logic signed [31:0]      o_val
);

  logic [ACC_W-32:0] upper;
  logic              fits;

  // The value fits when every bit above bit 30 equals the sign bit.
  assign upper = i_val[ACC_W-1:31];
  assign fits  = (&upper) | ~(|upper);

  always_comb begin
    o_val = i_val[31:0];
    if (!fits) begin
      o_val = i_val[ACC_W-1] ? ERR_MIN : ERR_MAX;
    end
  end

endmodule

// File: rtl/gyro_err_demod.sv
// Square-wave bias modulation and high-minus-low error demodulation.
// Optional GYRO_ERR_DEMOD_NORM_EN divides the error by the window length N.
module gyro_err_demod
  import gyro_demod_pkg::*;
#(
  parameter int unsigned ADC_BIT = 14,
  parameter int unsigned CNT_BIT = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [CNT_BIT-1:0]        i_freq,
  input  logic [CNT_BIT-1:0]        i_wait,
  input  logic [2:0]                i_avg_sel,
  input  logic                      i_polarity,
  input  logic signed [ADC_BIT-1:0] i_adc,
  output logic                      o_mod,
  output logic                      o_step_trig,
  output logic signed [31:0]        o_err,
  output logic                      o_err_valid
);

  state_e                   state_q, state_d;
  logic [CNT_BIT-1:0]       cnt_q, cnt_d;
  logic [CNT_BIT-1:0]       h_q, h_d;
  logic [CNT_BIT-1:0]       w_q, w_d;
  logic [2:0]               avg_q, avg_d;
  logic                     pol_q, pol_d;
  logic [PER_W-1:0]         per_q, per_d;
  logic signed [ACC_W-1:0]  sum_h_q, sum_h_d;
  logic signed [ACC_W-1:0]  sum_l_q, sum_l_d;
  logic                     mod_q, mod_d;
  logic                     trig_q, trig_d;
  logic                     valid_q, valid_d;
  logic signed [31:0]       err_q, err_d;

  logic [CNT_BIT-1:0]       h_cfg, w_cfg, cnt_inc;
  logic                     cnt_last, per_last;
  logic signed [ACC_W-1:0]  adc_ext, sum_l_fin, diff;
  logic signed [31:0]       err_sat, err_new;

  assign h_cfg = (i_freq < CNT_BIT'(2)) ? CNT_BIT'(2) : i_freq;
  assign w_cfg = (i_wait > h_cfg - CNT_BIT'(1)) ? h_cfg - CNT_BIT'(1) : i_wait;

  assign adc_ext  = {{(ACC_W-ADC_BIT){i_adc[ADC_BIT-1]}}, i_adc};
  assign cnt_inc  = cnt_q + CNT_BIT'(1);
  assign cnt_last = (cnt_q == h_q - CNT_BIT'(1));
  assign per_last = (per_q == (PER_W'(1) << avg_q) - PER_W'(1));

  // The window's final low sample is folded in before the subtraction.
  assign sum_l_fin = sum_l_q + adc_ext;
  assign diff      = pol_q ? (sum_l_fin - sum_h_q) : (sum_h_q - sum_l_fin);

  demod_sat32 u_sat (
    .i_val (diff),
    .o_val (err_sat)
  );

`ifdef GYRO_ERR_DEMOD_NORM_EN
  assign err_new = err_sat >>> avg_q;
`else
  assign err_new = err_sat;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    h_d     = h_q;
    w_d     = w_q;
    avg_d   = avg_q;
    pol_d   = pol_q;
    per_d   = per_q;
    sum_h_d = sum_h_q;
    sum_l_d = sum_l_q;
    mod_d   = mod_q;
    trig_d  = 1'b0;
    valid_d = 1'b0;
    err_d   = err_q;

    case (state_q)
      INIT: begin
        h_d     = h_cfg;
        w_d     = w_cfg;
        avg_d   = i_avg_sel;
        pol_d   = i_polarity;
        cnt_d   = '0;
        per_d   = '0;
        sum_h_d = '0;
        sum_l_d = '0;
        mod_d   = 1'b1;
        trig_d  = 1'b1;
        state_d = (w_cfg == '0) ? HIGH_ACC : HIGH_WAIT;
      end

      HIGH_WAIT, HIGH_ACC: begin
        if (state_q == HIGH_ACC) begin
          sum_h_d = sum_h_q + adc_ext;
        end
        if (cnt_last) begin
          cnt_d   = '0;
          mod_d   = 1'b0;
          trig_d  = 1'b1;
          state_d = (w_q == '0) ? LOW_ACC : LOW_WAIT;
        end else begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc >= w_q) ? HIGH_ACC : HIGH_WAIT;
        end
      end

      LOW_WAIT, LOW_ACC: begin
        if (state_q == LOW_ACC) begin
          sum_l_d = sum_l_fin;
        end
        if (cnt_last) begin
          cnt_d  = '0;
          mod_d  = 1'b1;
          trig_d = 1'b1;
          if (per_last) begin
            err_d   = err_new;
            valid_d = 1'b1;
            sum_h_d = '0;
            sum_l_d = '0;
            per_d   = '0;
            h_d     = h_cfg;
            w_d     = w_cfg;
            avg_d   = i_avg_sel;
            pol_d   = i_polarity;
            state_d = (w_cfg == '0) ? HIGH_ACC : HIGH_WAIT;
          end else begin
            per_d   = per_q + PER_W'(1);
            state_d = (w_q == '0) ? HIGH_ACC : HIGH_WAIT;
          end
        end else begin
          cnt_d   = cnt_inc;
          state_d = (cnt_inc >= w_q) ? LOW_ACC : LOW_WAIT;
        end
      end

      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      h_q     <= '0;
      w_q     <= '0;
      avg_q   <= '0;
      pol_q   <= 1'b0;
      per_q   <= '0;
      sum_h_q <= '0;
      sum_l_q <= '0;
      mod_q   <= 1'b0;
      trig_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      h_q     <= h_d;
      w_q     <= w_d;
      avg_q   <= avg_d;
      pol_q   <= pol_d;
      per_q   <= per_d;
      sum_h_q <= sum_h_d;
      sum_l_q <= sum_l_d;
      mod_q   <= mod_d;
      trig_q  <= trig_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign o_mod       = mod_q;
  assign o_step_trig = trig_q;
  assign o_err       = err_q;
  assign o_err_valid = valid_q;

endmodule

// File: tb/tb_gyro_err_demod.sv
// Bench for gyro_err_demod: per-cycle comparison against a window-position model.
module tb_gyro_err_demod;

  localparam int unsigned ADC_W = 24;
  localparam int unsigned CNT_W = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [CNT_W-1:0]        freq, wt;
  logic [2:0]              avg;
  logic                    pol;
  logic signed [ADC_W-1:0] adc;
  logic                    mod, trig, valid;
  logic signed [31:0]      err;

  always #5 clk = ~clk;

  gyro_err_demod #(
    .ADC_BIT (ADC_W),
    .CNT_BIT (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_freq      (freq),
    .i_wait      (wt),
    .i_avg_sel   (avg),
    .i_polarity  (pol),
    .i_adc       (adc),
    .o_mod       (mod),
    .o_step_trig (trig),
    .o_err       (err),
    .o_err_valid (valid)
  );

  int     total = 0;
  int     bad   = 0;

  // Model: latched config, position within the current window, half sums.
  int     mh, mw, mn, mavg;
  bit     mpol;
  int     p;
  longint sh, sl, e_err;
  bit     e_valid;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  task automatic latch_cfg();
    mh   = (freq < 2) ? 2 : int'(freq);
    mw   = (int'(wt) > mh - 1) ? mh - 1 : int'(wt);
    mavg = int'(avg);
    mn   = 1 << mavg;
    mpol = pol;
  endtask

  task automatic do_reset(input int f, input int w, input int a, input bit pl);
    @(negedge clk);
    rst  = 1'b1;
    freq = CNT_W'(f);
    wt   = CNT_W'(w);
    avg  = 3'(a);
    pol  = pl;
    adc  = '0;
    @(negedge clk);
    check("rst_mod", longint'(mod), 0);
    check("rst_trig", longint'(trig), 0);
    check("rst_valid", longint'(valid), 0);
    check("rst_err", longint'(err), 0);
    rst     = 1'b0;
    p       = 0;
    sh      = 0;
    sl      = 0;
    e_err   = 0;
    e_valid = 1'b0;
    latch_cfg();
  endtask

  task automatic run(input int cycles, input int amp_h, input int amp_l,
                     input bit rnd, input bit jitter);
    for (int i = 0; i < cycles; i++) begin
      bit     em;
      int     v;
      longint d;
      @(negedge clk);
      em = ((p / mh) % 2) == 0;
      check("mod", longint'(mod), longint'(em));
      check("trig", longint'(trig), longint'((p % mh) == 0));
      check("valid", longint'(valid), longint'(e_valid));
      check("err", longint'(err), e_err);

      if (rnd) v = int'($urandom_range(0, 16383)) - 8192;
      else     v = em ? amp_h : amp_l;
      adc = ADC_W'(v);

      if (jitter && ($urandom_range(0, 7) == 0)) begin
        freq = CNT_W'($urandom_range(0, 9));
        wt   = CNT_W'($urandom_range(0, 9));
        avg  = 3'($urandom_range(0, 2));
        pol  = 1'($urandom_range(0, 1));
      end

      if ((p % mh) >= mw) begin
        if (em) sh += v;
        else    sl += v;
      end

      e_valid = 1'b0;
      if (p == 2 * mh * mn - 1) begin
        d = mpol ? (sl - sh) : (sh - sl);
        if (d > 64'sd2147483647)  d = 64'sd2147483647;
        if (d < -64'sd2147483648) d = -64'sd2147483648;
`ifdef GYRO_ERR_DEMOD_NORM_EN
        d = d >>> mavg;
`endif
        e_err   = d;
        e_valid = 1'b1;
        sh      = 0;
        sl      = 0;
        p       = 0;
        latch_cfg();
      end else begin
        p++;
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    freq = '0;
    wt   = '0;
    avg  = '0;
    pol  = 1'b0;
    adc  = '0;

    do_reset(4, 1, 0, 0);
    run(3 * 8 + 1, 100, -100, 1'b0, 1'b0);
    do_reset(4, 1, 0, 1);
    run(3 * 8 + 1, 100, -100, 1'b0, 1'b0);
    do_reset(4, 10, 0, 0);
    run(3 * 8 + 1, 100, -100, 1'b0, 1'b0);
    do_reset(4, 1, 2, 0);
    run(3 * 32 + 1, 100, -100, 1'b0, 1'b0);

    do_reset(1000, 0, 1, 0);
    run(4001, 8388607, -8388608, 1'b0, 1'b0);
    do_reset(1000, 0, 1, 1);
    run(4001, 8388607, -8388608, 1'b0, 1'b0);

    do_reset(5, 4, 1, 0);
    run(2 * 20 + 1, 0, 0, 1'b1, 1'b0);
    do_reset(0, 0, 1, 1);
    run(3 * 8 + 1, 0, 0, 1'b1, 1'b0);

    do_reset(6, 2, 1, 0);
    run(17, 0, 0, 1'b1, 1'b0);
    do_reset(6, 2, 1, 0);
    run(2 * 24 + 1, 0, 0, 1'b1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      do_reset(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      run(int'($urandom_range(30, 200)), 0, 0, 1'b1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
